// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift/rotate issue stage.
package shift_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ROR = 3'd0,
    OP_ROL = 3'd1,
    OP_SRL = 3'd2,
    OP_SLL = 3'd3,
    OP_SRA = 3'd4
  } shift_op_e;

  typedef struct packed {
    shift_op_e         op;
    logic [DATA_W-1:0] a;
    logic [2:0]        n;
  } fifo_entry_t;

  // Ones in the top n bit positions (the bits a right shift vacates).
  function automatic logic [DATA_W-1:0] top_mask(input logic [2:0] n);
    return ~(8'hFF >> n);
  endfunction

  // Ones in the low n bit positions (the bits a left shift vacates).
  function automatic logic [DATA_W-1:0] low_mask(input logic [2:0] n);
    return ~(8'hFF << n);
  endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Request/result handshake bundle of the shift issue stage.
interface shift_issue_stage_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [2:0]        in_n;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;

  modport slave (
    input  in_valid, in_op, in_a, in_n, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

  modport master (
    output in_valid, in_op, in_a, in_n, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/rot8.sv
// Combinational 8-bit rotate-right, three mux2 stages by 4, 2 and 1.
module rot8
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [2:0]        n_i,
  output logic [DATA_W-1:0] y_o
);
  logic [DATA_W-1:0] s4;
  logic [DATA_W-1:0] s2;

  assign s4  = n_i[2] ? {a_i[3:0], a_i[7:4]} : a_i;
  assign s2  = n_i[1] ? {s4[1:0], s4[7:2]}   : s4;
  assign y_o = n_i[0] ? {s2[0], s2[7:1]}     : s2;
endmodule

// File: rtl/shift_issue_stage.sv
// Shift/rotate issue stage: request FIFO, rotator-based shift unit and
// registered result. Optional op counter port enabled by SHIFT_STATS_EN.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  shift_issue_stage_if.slave bus
`ifdef SHIFT_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  fifo_entry_t       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              in_ready, push, pop;
  fifo_entry_t       head, wr_entry;
  logic [2:0]        rot_amt;
  logic [DATA_W-1:0] rot_out;
  logic              right_c, left_c;
  logic [DATA_W-1:0] res_data_d;
  logic              res_carry_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_carry_q;

  // in_ready looks only at the registered count, so a same-cycle pop never raises it.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = (count_q != {CW{1'b0}}) & (~out_valid_q | bus.out_ready);
  assign wr_entry = '{op: shift_op_e'(bus.in_op), a: bus.in_a, n: bus.in_n};
  assign head     = mem_q[rd_ptr_q];

  // Bit shifted out last; n=0 shifts nothing out.
  assign right_c = (head.n != 3'd0) ? head.a[head.n - 3'd1] : 1'b0;
  assign left_c  = (head.n != 3'd0) ? head.a[3'd0 - head.n] : 1'b0;

  // Left flavours rotate right by (8-n) mod 8.
  always_comb begin
    rot_amt = head.n;
    case (head.op)
      OP_ROL, OP_SLL: rot_amt = 3'd0 - head.n;
      default:        rot_amt = head.n;
    endcase
  end

  rot8 u_rot8 (
    .a_i (head.a),
    .n_i (rot_amt),
    .y_o (rot_out)
  );

  // Mask/fill the rotated value and pick the carry for the head request.
  always_comb begin
    res_data_d  = head.a;
    res_carry_d = 1'b0;
    case (head.op)
      OP_ROR: begin
        res_data_d  = rot_out;
        res_carry_d = right_c;
      end
      OP_ROL: begin
        res_data_d  = rot_out;
        res_carry_d = left_c;
      end
      OP_SRL: begin
        res_data_d  = rot_out & ~top_mask(head.n);
        res_carry_d = right_c;
      end
      OP_SLL: begin
        res_data_d  = rot_out & ~low_mask(head.n);
        res_carry_d = left_c;
      end
      OP_SRA: begin
        if (head.a[DATA_W-1]) begin
          res_data_d = rot_out | top_mask(head.n);
        end else begin
          res_data_d = rot_out & ~top_mask(head.n);
        end
        res_carry_d = right_c;
      end
      default: begin
        res_data_d  = head.a;
        res_carry_d = 1'b0;
      end
    endcase
  end

  // Next pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result register: load on pop, clear when consumed with nothing behind, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_carry_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_data_d;
      out_carry_q <= res_carry_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;

`ifdef SHIFT_STATS_EN
  logic [15:0] op_count_q;

  // Count consumed results, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'h0000;
    end else if (out_valid_q & bus.out_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end else begin
      op_count_q <= op_count_q;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed and table-driven bench for shift_issue_stage (DEPTH=2).
module tb_shift_issue_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_issue_stage_if bus ();

`ifdef SHIFT_STATS_EN
  logic [15:0] op_count;
`endif

  shift_issue_stage #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHIFT_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [2:0] n;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  localparam int NHAND = 15;
  localparam int NVEC  = NHAND + 8;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [2:0] n);
    bus.in_op = op;
    bus.in_a  = a;
    bus.in_n  = n;
  endtask

  // Reference built from plain shifts, independent of any rotator.
  function automatic logic [8:0] ref_model(input logic [2:0] op, input logic [7:0] a, input logic [2:0] n);
    logic [15:0] aa;
    logic [15:0] sh;
    logic [7:0]  d;
    logic        c;
    int          ni;
    ni = int'(n);
    aa = {a, a};
    d  = a;
    c  = 1'b0;
    case (op)
      3'd0: begin
        sh = aa >> ni;
        d  = sh[7:0];
        c  = (ni == 0) ? 1'b0 : a[ni-1];
      end
      3'd1: begin
        sh = aa << ni;
        d  = sh[15:8];
        c  = (ni == 0) ? 1'b0 : a[8-ni];
      end
      3'd2: begin
        d = a >> ni;
        c = (ni == 0) ? 1'b0 : a[ni-1];
      end
      3'd3: begin
        d = a << ni;
        c = (ni == 0) ? 1'b0 : a[8-ni];
      end
      3'd4: begin
        d = 8'($signed(a) >>> ni);
        c = (ni == 0) ? 1'b0 : a[ni-1];
      end
      default: begin
        d = a;
        c = 1'b0;
      end
    endcase
    return {c, d};
  endfunction

  initial begin
    int          accepts;
    int          idx;
    int          stale;
    int          sent;
    int          got;
    int          gaps;
    bit          first_seen;
    bit          pending;
    logic [2:0]  r_op;
    logic [7:0]  r_a;
    logic [2:0]  r_n;
    logic [8:0]  exp_q [$];
    logic [8:0]  e;
    logic [7:0]  bp_a [4];

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 8'h00, 3'd0);

    vecs[0]  = '{3'd0, 8'h81, 3'd1, 8'hC0, 1'b1};
    vecs[1]  = '{3'd1, 8'h81, 3'd1, 8'h03, 1'b1};
    vecs[2]  = '{3'd3, 8'h81, 3'd3, 8'h08, 1'b0};
    vecs[3]  = '{3'd2, 8'h81, 3'd7, 8'h01, 1'b0};
    vecs[4]  = '{3'd4, 8'h90, 3'd2, 8'hE4, 1'b0};
    vecs[5]  = '{3'd4, 8'h70, 3'd3, 8'h0E, 1'b0};
    vecs[6]  = '{3'd0, 8'h01, 3'd1, 8'h80, 1'b1};
    vecs[7]  = '{3'd3, 8'hFF, 3'd7, 8'h80, 1'b1};
    vecs[8]  = '{3'd2, 8'h80, 3'd7, 8'h01, 1'b0};
    vecs[9]  = '{3'd4, 8'h80, 3'd7, 8'hFF, 1'b0};
    vecs[10] = '{3'd1, 8'h80, 3'd1, 8'h01, 1'b1};
    vecs[11] = '{3'd6, 8'h3C, 3'd5, 8'h3C, 1'b0};
    vecs[12] = '{3'd0, 8'h5A, 3'd4, 8'hA5, 1'b1};
    vecs[13] = '{3'd2, 8'h0F, 3'd4, 8'h00, 1'b1};
    vecs[14] = '{3'd3, 8'hF0, 3'd4, 8'h00, 1'b1};
    for (int i = 0; i < 8; i++) begin
      vecs[NHAND + i] = '{3'(i), 8'h5A, 3'd0, 8'h5A, 1'b0};
    end

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SHIFT_STATS_EN
    chk("rst_op_count", 32'(op_count), 32'd0);
`endif

    // Table: one request at a time, result two edges after it is offered
    bus.out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].n);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), 32'({bus.out_carry, bus.out_data}),
          32'({vecs[i].exp_c, vecs[i].exp_d}));
    end

    // Backpressure: out_ready low, offer 4 requests, only 3 fit
    do_reset();
    bp_a[0] = 8'h11;
    bp_a[1] = 8'h22;
    bp_a[2] = 8'h33;
    bp_a[3] = 8'h44;
    accepts = 0;
    idx     = 0;
    for (int c = 0; c < 6; c++) begin
      drive(3'd5, bp_a[idx], 3'd3);
      bus.in_valid = 1'b1;
      if (bus.in_ready && idx < 3) begin
        accepts++;
        idx++;
      end else if (bus.in_ready) begin
        accepts++;
      end else begin
        accepts = accepts;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", 32'(accepts), 32'd3);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_data", 32'(bus.out_data), 32'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain1", 32'({bus.out_valid, bus.out_data}), 32'h122);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_drain2", 32'({bus.out_valid, bus.out_data}), 32'h133);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation with 3 requests in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(3'd0, 8'hA0 + 8'(c), 3'd1);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SHIFT_STATS_EN
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
`endif
    bus.out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);

    // Streaming: 100 random back-to-back requests, out_ready high
    sent       = 0;
    got        = 0;
    gaps       = 0;
    first_seen = 1'b0;
    pending    = 1'b0;
    r_op = 3'd0;
    r_a  = 8'h00;
    r_n  = 3'd0;
    for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream%0d", got), 32'({bus.out_carry, bus.out_data}), 32'(e));
        end
        got++;
        first_seen = 1'b1;
      end else if (first_seen) begin
        gaps++;
      end
      if (sent < 100) begin
        if (!pending) begin
          r_op    = 3'($urandom_range(0, 7));
          r_a     = 8'($urandom_range(0, 255));
          r_n     = 3'($urandom_range(0, 7));
          pending = 1'b1;
        end
        drive(r_op, r_a, r_n);
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          exp_q.push_back(ref_model(r_op, r_a, r_n));
          sent++;
          pending = 1'b0;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'd100);
    chk("stream_gaps", 32'(gaps), 32'd0);
    tick();
`ifdef SHIFT_STATS_EN
    chk("stream_op_count", 32'(op_count), 32'd100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
